// File: rtl/fc_input_collector_if.sv
// Stream-in / frame-out handshake bundle for the fully-connected layer input collector.
// The slave modport is the collector; the master modport is the upstream source plus the layer consumer.
interface fc_input_collector_if #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_data;
    logic                    s_last;
    logic signed [WIDTH-1:0] x [0:IN-1];
    logic                    x_valid;
    logic                    x_ready;

    modport master (
        output s_valid, s_data, s_last, x_ready,
        input  s_ready, x, x_valid
    );

    modport slave (
        input  s_valid, s_data, s_last, x_ready,
        output s_ready, x, x_valid
    );
endinterface

// File: rtl/fc_input_collector.sv
// Ping-pong frame assembler: packs IN streamed activations into a parallel vector for the layer.
// One bank fills from the stream while the other is presented on x until the layer consumes it.
module fc_input_collector #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                clk,
    input  logic                rst,
    fc_input_collector_if.slave bus,
    output logic                len_err,
    output logic [15:0]         frame_cnt
);
    localparam int               IDX_W      = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(IN - 1);
    localparam logic [0:0]       BANK_EMPTY = 1'b0;
    localparam logic [0:0]       BANK_FULL  = 1'b1;

    logic [IN-1:0][WIDTH-1:0] bank    [2];
    logic [0:0]               bank_st [2];
    logic                     wr_bank;
    logic                     rd_bank;
    logic [IDX_W-1:0]         wr_idx;
    logic                     accept;
    logic                     rel;
    logic                     close;
    logic                     frame_err;

    // The write bank is never FULL while accepting, so a close and a release never hit the same bank.
    assign bus.s_ready = (bank_st[wr_bank] != BANK_FULL);
    assign bus.x_valid = (bank_st[rd_bank] == BANK_FULL);
    assign accept      = bus.s_valid && bus.s_ready;
    assign rel         = bus.x_valid && bus.x_ready;
    assign close       = accept && (bus.s_last || (wr_idx == LAST_IDX));
    // A length error is any close where s_last disagrees with the frame position.
    assign frame_err   = close && (bus.s_last != (wr_idx == LAST_IDX));

    for (genvar i = 0; i < IN; i++) begin : g_x
        assign bus.x[i] = bank[rd_bank][i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the bank storage is reset, not just flagged empty, because unwritten entries of a short frame must read as 0.
            bank[0]    <= '0;
            bank[1]    <= '0;
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_idx     <= '0;
            len_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (accept) begin
                bank[wr_bank][wr_idx] <= bus.s_data;
                if (close) begin
                    bank_st[wr_bank] <= BANK_FULL;
                    wr_bank          <= ~wr_bank;
                    wr_idx           <= '0;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (frame_err) begin
                len_err <= 1'b1;
            end
            // Clearing on release keeps the zero-fill guarantee for the next short frame in this bank.
            if (rel) begin
                bank[rd_bank]    <= '0;
                bank_st[rd_bank] <= BANK_EMPTY;
                rd_bank          <= ~rd_bank;
                frame_cnt        <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/fc_input_collector.md
Name: fc_input_collector

Overview:
- Upstream feeder for the combinational fully-connected `layer` neuron block.
- Accepts activations one element per beat on a valid/ready stream and assembles each frame of IN elements into a parallel vector.
- Presents that vector as the layer's `x[0:IN-1]` input, held stable while `x_valid` is high.
- Two ping-pong banks, so the next frame fills while the current one is consumed.

Parameters:
- WIDTH, 8, bits per activation element; matches the layer's WIDTH.
- IN, 128, elements per frame; matches the layer's IN.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- s_valid  input  1  upstream element valid
- s_ready  output  1  collector can accept an element
- s_data  input  WIDTH  activation element, signed two's complement
- s_last  input  1  marks final element of a frame
- x  output  WIDTH x [0:IN-1]  parallel frame vector to layer, unpacked array
- x_valid  output  1  x holds a complete frame
- x_ready  input  1  downstream has consumed x
- len_err  output  1  sticky frame-length error flag
- frame_cnt  output  16  count of frames released downstream

Behaviour:
- Reset:
  - Both banks cleared to 0 and marked EMPTY.
  - wr_bank=0, rd_bank=0, wr_idx=0.
  - s_ready=1, x_valid=0, x=all 0, len_err=0, frame_cnt=0.
  - Reset mid-frame discards partial and full frames alike.
- Bank state: each bank is EMPTY (also covers partially filled) or FULL.
- Write side:
  - s_ready = (bank[wr_bank] != FULL); combinational from registered state only, no dependence on s_valid.
  - Accept when s_valid && s_ready: store s_data at bank[wr_bank][wr_idx].
  - Frame close when the accepted beat has wr_idx==IN-1 or s_last=1: mark bank FULL, wr_idx<=0, toggle wr_bank.
  - Otherwise wr_idx<=wr_idx+1.
- Early s_last (wr_idx<IN-1):
  - Frame closes immediately.
  - Unwritten entries stay 0, guaranteed by bank clear on release/reset.
  - len_err<=1.
- Missing s_last at wr_idx==IN-1: frame still closes, len_err<=1.
- len_err clears only on rst.
- Read side:
  - x = bank[rd_bank], driven combinationally from bank registers.
  - x_valid = (bank[rd_bank]==FULL).
  - x and x_valid are stable while x_valid=1 && x_ready=0.
- Release on x_valid && x_ready:
  - bank[rd_bank] cleared to all 0 and marked EMPTY.
  - Toggle rd_bank.
  - frame_cnt<=frame_cnt+1, wrapping 0xFFFF->0.
- Latency:
  - Closing beat accepted in cycle t -> x_valid=1 in cycle t+1, if that bank is rd_bank.
  - The layer's z is valid combinationally in the same cycle; downstream registers it and asserts x_ready.
- Simultaneous events:
  - A close into one bank and a release of the other in the same cycle both take effect.
  - Same-bank conflict cannot occur: the write bank is never FULL while accepting.
- Throughput:
  - With x_ready tied 1 and s_valid continuous: s_ready never deasserts.
  - One frame released every IN cycles.
- Backpressure: with x_ready=0, after both banks are FULL, s_ready=0 until a release. s_ready reasserts the cycle after the release.
- Empty frame: an s_last beat is never an empty frame; it always carries one element.

Test Plan:
- Reset then stream s_data=k (k=0..127), s_last on k=127, x_ready=1 -> x_valid for exactly 1 cycle at t+1; x[i]=i; frame_cnt=1; len_err=0.
- Two back-to-back frames (values i and 127-i), x_ready=0 -> after 256 beats s_ready=0 and x[5]=5 held stable. Raise x_ready 1 cycle -> x[5]=122, x_valid=1, s_ready=1 next cycle, frame_cnt=1.
- Short frame of 10 beats (values 0x11) with s_last on beat 10 -> x[0..9]=0x11, x[10..127]=0, len_err=1 sticky across later good frames.
- Long frame of 128 beats with no s_last, then 128 more beats with s_last -> two frames released, len_err=1, frame_cnt=2.
- Assert rst at beat 60 of a frame with other bank FULL -> next cycle x_valid=0, s_ready=1, x all 0, frame_cnt=0. Fresh frame after reset reads back correctly.
- Preload frame_cnt=0xFFFF via 65535 short 1-beat frames (s_last=1), x_ready=1 -> next release wraps frame_cnt to 0x0000.
